// File: rtl/ysyx_220053_mdu.sv
// ----------------------------------------------------------------------------
// ysyx_220053_mdu
// Iterative RISC-V M-extension multiply/divide unit.
//   mul*  : radix-2 shift-add over operand magnitudes, one step per BUSY cycle
//   div*  : restoring shift-subtract over magnitudes, one step per BUSY cycle
//   FIXUP : applies sign correction and selects the architectural result
// Divide-by-zero and signed overflow skip BUSY and go straight to FIXUP.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (in_ready only in IDLE)
//   func3, src1, src2   : operation select and operands, sampled at acceptance
//   flush               : abort, returns to IDLE on the next edge
//   out_valid/out_ready : result handshake (result held in DONE)
//   result              : operation result, forced to 0 when out_valid = 0
//   busy                : high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module ysyx_220053_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [6:0]      LAST = 7'(XLEN - 1);

    state_t              state_reg, state_next;
    logic [2:0]          func_reg;
    logic [XLEN-1:0]     operand_reg;   // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0]   work_reg;      // mul: {acc, multiplier}; div: {remainder, quotient}
    logic [6:0]          count_reg;
    logic                neg_q_reg;     // product / quotient must be negated
    logic                neg_r_reg;     // remainder must be negated
    logic [XLEN-1:0]     result_reg;

    // ------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic            is_div;
    logic            s1_signed, s2_signed;
    logic            s1_neg, s2_neg;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf, bypass;
    logic            accept;

    always_comb begin
        is_div    = func3[2];
        // mulh, mulhsu, div, rem treat src1 as signed; mulh, div, rem treat src2 as signed.
        // Plain mul only keeps the low half, which is the same for any signedness.
        s1_signed = (func3 == 3'b001) || (func3 == 3'b010) || (func3[2] && !func3[0]);
        s2_signed = (func3 == 3'b001) || (func3[2] && !func3[0]);
        s1_neg    = s1_signed && src1[XLEN-1];
        s2_neg    = s2_signed && src2[XLEN-1];
        mag1      = s1_neg ? (~src1 + 1'b1) : src1;
        mag2      = s2_neg ? (~src2 + 1'b1) : src2;
        div_zero  = is_div && (src2 == '0);
        div_ovf   = is_div && !func3[0] && (src1 == SMIN) && (src2 == '1);
        bypass    = div_zero || div_ovf;
    end

    assign accept = (state_reg == IDLE) && in_valid && !flush;

    // ------------------------------------------------------------------
    // Iteration step datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_partial;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_step;

    always_comb begin
        // Add multiplicand into the upper half when the multiplier LSB is set,
        // then shift the whole product register right by one (carry enters at top).
        mul_sum  = {1'b0, work_reg[2*XLEN-1:XLEN]} + (work_reg[0] ? {1'b0, operand_reg} : '0);
        mul_step = {mul_sum, work_reg[XLEN-1:1]};

        // Bring the next dividend bit into the remainder and trial-subtract.
        // The remainder is always below the divisor, so the partial fits XLEN+1 bits
        // and the top bit of the difference is a clean borrow flag.
        div_partial = {work_reg[2*XLEN-1:XLEN], work_reg[XLEN-1]};
        div_diff    = div_partial - {1'b0, operand_reg};
        if (div_diff[XLEN])
            div_step = {div_partial[XLEN-1:0], work_reg[XLEN-2:0], 1'b0};
        else
            div_step = {div_diff[XLEN-1:0], work_reg[XLEN-2:0], 1'b1};
    end

    // ------------------------------------------------------------------
    // Sign correction and result select
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix = neg_q_reg ? (~work_reg + 1'b1) : work_reg;
        quo_fix  = neg_q_reg ? (~work_reg[XLEN-1:0] + 1'b1) : work_reg[XLEN-1:0];
        rem_fix  = neg_r_reg ? (~work_reg[2*XLEN-1:XLEN] + 1'b1) : work_reg[2*XLEN-1:XLEN];
        if (func_reg[2])
            fix_result = func_reg[1] ? rem_fix : quo_fix;
        else if (func_reg[1:0] == 2'b00)
            fix_result = prod_fix[XLEN-1:0];
        else
            fix_result = prod_fix[2*XLEN-1:XLEN];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (in_valid) state_next = bypass ? FIXUP : BUSY;
                BUSY:    if (count_reg == LAST) state_next = FIXUP;
                FIXUP:   state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_reg    <= '0;
            operand_reg <= '0;
            work_reg    <= '0;
            count_reg   <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            result_reg  <= '0;
        end else begin
            if (accept) begin
                func_reg  <= func3;
                count_reg <= '0;
                if (bypass) begin
                    // Final quotient/remainder are known now; FIXUP passes them through.
                    operand_reg <= '0;
                    neg_q_reg   <= 1'b0;
                    neg_r_reg   <= 1'b0;
                    work_reg    <= div_zero ? {src1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, src1};
                end else begin
                    operand_reg <= is_div ? mag2 : mag1;
                    work_reg    <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                    neg_q_reg   <= s1_neg ^ s2_neg;
                    neg_r_reg   <= s1_neg;
                end
            end else if (!flush && state_reg == BUSY) begin
                work_reg  <= func_reg[2] ? div_step : mul_step;
                count_reg <= count_reg + 7'd1;
            end else if (!flush && state_reg == FIXUP) begin
                result_reg <= fix_result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = out_valid ? result_reg : '0;

endmodule

// File: doc/ysyx_220053_mdu.md
YSYX_220053_MDU -- requirements
Module: ysyx_220053_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 64, which sets the operand and result width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an operation request is present.
REQ-005 SHALL have port in_ready, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have port func3, input, 3 bits: operation select, 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-007 SHALL have port src1, input, XLEN bits: rs1 operand.
REQ-008 SHALL have port src2, input, XLEN bits: rs2 operand.
REQ-009 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port result, output, XLEN bits: operation result.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE; the pipeline uses it as a stall.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY, FIXUP and DONE.
REQ-015 SHALL drive in_ready = 1 only in IDLE; a request is accepted when in_valid and in_ready are both high at a rising edge.
REQ-016 On acceptance, SHALL latch func3, the operand magnitudes and the result sign, set the 7-bit iteration count to 0, and go IDLE->BUSY.
REQ-017 mul*: SHALL perform one radix-2 shift-add step per BUSY cycle over the magnitudes, building a 2*XLEN product.
REQ-018 div/rem*: SHALL perform one restoring shift-subtract step per BUSY cycle, producing a quotient and remainder.
REQ-019 Signedness rules:
- mulh: src1 and src2 are signed.
- mulhsu: src1 is signed, src2 is unsigned.
- mulhu, divu, remu: all operands are unsigned.
- div, rem: both operands are signed.
REQ-020 SHALL leave BUSY for FIXUP when the count reaches XLEN-1, i.e. after exactly XLEN BUSY cycles.
REQ-021 FIXUP (1 cycle), sign correction:
- SHALL negate the product if the product sign is negative.
- SHALL negate the quotient if the operand signs differ.
- SHALL give the remainder the sign of the dividend.
REQ-022 FIXUP (1 cycle), result select:
- mul: low XLEN bits of the product.
- mulh*: high XLEN bits of the product.
- div*: quotient.
- rem*: remainder.
REQ-023 After FIXUP, SHALL go to DONE.
REQ-024 Normal latency SHALL be XLEN+2 cycles from the acceptance edge to the first cycle with out_valid = 1 (66 cycles for XLEN=64).
REQ-025 Divide by zero (src2 = 0) SHALL bypass BUSY and go IDLE->FIXUP.
REQ-026 Divide-by-zero results: quotient = all ones; remainder = src1.
REQ-027 Signed overflow (div/rem, src1 = signed minimum, src2 = -1) SHALL bypass BUSY and go IDLE->FIXUP.
REQ-028 Signed-overflow results: quotient = src1; remainder = 0.
REQ-029 The latency of a bypassed operation SHALL be 2 cycles.
REQ-030 DONE SHALL hold out_valid = 1 and keep result stable until out_ready = 1 at a rising edge.
REQ-031 When out_ready = 1 in DONE, SHALL go DONE->IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-032 flush = 1 SHALL force IDLE on the next edge from any state, with no out_valid produced; flush has priority over acceptance and completion.
REQ-033 result SHALL be 0 whenever out_valid = 0.
REQ-034 in_valid in a non-IDLE state SHALL be ignored, and operands SHALL NOT be sampled.
REQ-035 func3 and operands SHALL be sampled only at acceptance; later input changes SHALL have no effect.

Reset
REQ-036 rst_n = 0 SHALL asynchronously force IDLE and clear the count and all datapath registers.
REQ-037 During reset: out_valid = 0, result = 0, busy = 0, in_ready = 1.
REQ-038 Reset asserted mid-operation SHALL discard the operation, with no out_valid after reset is released.

Verification
REQ-039 mul: src1 = 7, src2 = -3 -> result = -21 (0xFFFFFFFFFFFFFFEB), out_valid exactly 66 cycles after acceptance.
REQ-040 mulhu: src1 = src2 = 0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; mulh on the same operands -> 0.
REQ-041 Special divides, each with out_valid at cycle 2:
- div src1 = -7, src2 = 0 -> all ones.
- rem src1 = -7, src2 = 0 -> -7.
- div src1 = 0x8000000000000000, src2 = -1 -> 0x8000000000000000.
- rem same operands -> 0.
REQ-042 Normal signed divide: div -7 / 2 -> -3; rem -7 / 2 -> -1; remu 7 / 2 -> 1.
REQ-043 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> result is stable and in_ready = 0 throughout; raise out_ready -> IDLE on the next cycle.
REQ-044 Abort: flush at BUSY cycle 30 -> IDLE with no out_valid. Reset at cycle 40 of a new operation -> outputs at reset values immediately, no stale completion.
